// File: rtl/counter_pkg.sv
// Shared defaults and the count type for the free-running up-counter family.
package counter_pkg;

  localparam int unsigned COUNT_WIDTH       = 4;
  localparam int unsigned COUNT_RESET_VALUE = 0;
  localparam int unsigned COUNT_STEP        = 1;

  typedef logic [COUNT_WIDTH-1:0] count_t;

  // True when value is representable in width bits (width 1..32).
  function automatic bit fits_width(input int unsigned value, input int unsigned width);
    return (width >= 32) || (64'(value) < (64'd1 << width));
  endfunction

endpackage

// File: rtl/counter_next.sv
// Pure combinational next-state function: reset wins, otherwise add STEP modulo 2^WIDTH.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = COUNT_WIDTH,
  parameter int unsigned RESET_VALUE = COUNT_RESET_VALUE,
  parameter int unsigned STEP        = COUNT_STEP
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             RES,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);
  // Truncating STEP to WIDTH+1 bits keeps the sum congruent modulo 2^WIDTH.
  localparam logic [WIDTH:0]   STEP_V = (WIDTH+1)'(STEP);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, cnt} + STEP_V;
    nxt = sum[WIDTH-1:0];
    if (RES) begin
      nxt = RST_V;
    end
  end

endmodule

// File: rtl/up_counter4.sv
// Free-running synchronous up-counter; Q is the count register with no input-to-output path.
module up_counter4
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = COUNT_WIDTH,
  parameter int unsigned RESET_VALUE = COUNT_RESET_VALUE,
  parameter int unsigned STEP        = COUNT_STEP
) (
  input  logic             CLK,
  input  logic             RES,
  output logic [WIDTH-1:0] Q
);

  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $error("up_counter4: WIDTH must be in 1..32");
  end
  if (!fits_width(RESET_VALUE, WIDTH)) begin : g_bad_reset
    $error("up_counter4: RESET_VALUE does not fit in WIDTH bits");
  end
  if (STEP < 1) begin : g_bad_step
    $error("up_counter4: STEP must be at least 1");
  end

  // Declaration initialiser gives the power-up value without needing a reset.
  logic [WIDTH-1:0] cnt_q = WIDTH'(RESET_VALUE);
  logic [WIDTH-1:0] cnt_d;

  counter_next #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .STEP        (STEP)
  ) u_next (
    .cnt (cnt_q),
    .RES (RES),
    .nxt (cnt_d)
  );

  always_ff @(posedge CLK) begin
    cnt_q <= cnt_d;
  end

  assign Q = cnt_q;

  a_res_known : assert property (@(posedge CLK) !$isunknown(RES));

endmodule

// File: tb/tb_up_counter4.sv
// Directed bench for up_counter4: default instance plus a WIDTH=3/RESET_VALUE=5/STEP=3 instance.
module tb_up_counter4;

  logic       CLK = 1'b0;
  logic       RES = 1'b0;
  logic       RES2 = 1'b1;
  logic [3:0] Q;
  logic [2:0] Q2;

  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  up_counter4 dut (
    .CLK (CLK),
    .RES (RES),
    .Q   (Q)
  );

  up_counter4 #(
    .WIDTH       (3),
    .RESET_VALUE (5),
    .STEP        (3)
  ) dut2 (
    .CLK (CLK),
    .RES (RES2),
    .Q   (Q2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int exp2 [8] = '{0, 3, 6, 1, 4, 7, 2, 5};

    #1;
    chk("powerup_q", 32'(Q), 32'd0);
    chk("powerup_q2", 32'(Q2), 32'd5);

    edges(1);
    chk("first_edge", 32'(Q), 32'd1);
    // RES pulse strictly between posedges (12..14 ns) must be ignored.
    #2 RES = 1'b1;
    #2 RES = 1'b0;
    edges(1);
    chk("pulse_ignored", 32'(Q), 32'd2);
    edges(1);
    chk("third_edge", 32'(Q), 32'd3);

    edges(12);
    chk("reach_15", 32'(Q), 32'd15);
    edges(1);
    chk("wrap_0", 32'(Q), 32'd0);
    edges(1);
    chk("after_wrap", 32'(Q), 32'd1);

    edges(8);
    chk("reach_9", 32'(Q), 32'd9);
    RES = 1'b1;
    edges(1);
    chk("reset_mid", 32'(Q), 32'd0);
    RES = 1'b0;
    edges(1);
    chk("post_reset1", 32'(Q), 32'd1);

    RES = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      chk($sformatf("reset_hold%0d", i), 32'(Q), 32'd0);
    end
    RES = 1'b0;
    edges(1);
    chk("release1", 32'(Q), 32'd1);
    edges(1);
    chk("release2", 32'(Q), 32'd2);

    chk("sweep_reset", 32'(Q2), 32'd5);
    RES2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edges(1);
      chk($sformatf("sweep%0d", i), 32'(Q2), 32'(exp2[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: observed no completion expected finish by 5000ns");
    $fatal(1, "timeout");
  end

endmodule
